// File: rtl/muxn_arb_reg.sv
// N-channel round-robin arbiter feeding a single-entry valid/ready output register.
// Optional burst locking is enabled with `define MUXN_LOCK_EN (adds in_last/out_last/dbg_state).
module muxn_arb_reg #(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 4,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUXN_LOCK_EN
  ,
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last,
  output logic                      dbg_state
`endif
);

  // Handshake: a beat moves on any edge where valid and ready are both high;
  // valid never waits on ready, and ready may depend combinationally on valid.

  logic [SELW-1:0]     r_ptr;
  logic [WIDTH-1:0]    r_out_data;
  logic [SELW-1:0]     r_out_sel;
  logic                r_out_valid;

  logic                w_load;
  logic                w_xfer;
  logic                w_found;
  logic [SELW-1:0]     w_gnt;
  logic [SELW:0]       w_pick;
  logic [CHANNELS-1:0] w_elig;
  logic [SELW-1:0]     w_ptr_nxt;
  logic [WIDTH-1:0]    w_sel_data;

  // Pointer wraps at the last real channel, not at 2^SELW.
  function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] v);
    return (v == SELW'(CHANNELS - 1)) ? '0 : v + SELW'(1);
  endfunction

  // Returns {found, index} of the first requester at or after ptr (circular).
  function automatic logic [SELW:0] rr_pick(input logic [CHANNELS-1:0] req,
                                            input logic [SELW-1:0]     ptr);
    logic [SELW:0] res;
    int            idx;
    res = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (req[idx]) res = {1'b1, idx[SELW-1:0]};
    end
    return res;
  endfunction

  assign w_load  = !rst && (!r_out_valid || out_ready);
  assign w_pick  = rr_pick(w_elig, r_ptr);
  assign w_found = w_pick[SELW];
  assign w_gnt   = w_pick[SELW-1:0];
  assign w_xfer  = w_load && w_found;

  always_comb begin
    in_ready = '0;
    if (w_xfer) in_ready[w_gnt] = 1'b1;
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_gnt == SELW'(i)) w_sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef MUXN_LOCK_EN
  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} lock_state_e;

  lock_state_e     r_state;
  lock_state_e     w_state_nxt;
  logic [SELW-1:0] r_owner;
  logic [SELW-1:0] w_owner_nxt;
  logic            r_out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // While locked only the burst owner may be granted, even if it is idle.
  always_comb begin
    w_elig = in_valid;
    if (r_state == S_LOCKED) begin
      w_elig          = '0;
      w_elig[r_owner] = in_valid[r_owner];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    if (w_xfer) begin
      case (r_state)
        S_IDLE: begin
          if (!in_last[w_gnt]) begin
            w_state_nxt = S_LOCKED;
            w_owner_nxt = w_gnt;
          end else begin
            w_ptr_nxt = wrap_inc(w_gnt);
          end
        end
        S_LOCKED: begin
          if (in_last[r_owner]) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = wrap_inc(r_owner);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_last <= 1'b0;
    end else if (w_xfer) begin
      r_out_last <= in_last[w_gnt];
    end
  end

  assign out_last  = r_out_last;
  assign dbg_state = r_state;
`else
  assign w_elig    = in_valid;
  assign w_ptr_nxt = w_xfer ? wrap_inc(w_gnt) : r_ptr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_xfer) begin
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_gnt;
        r_out_valid <= 1'b1;
      end else if (w_load) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_muxn_arb_reg.sv
// Directed bench for muxn_arb_reg: a 4-channel 32-bit instance and a 3-channel 8-bit instance.
module tb_muxn_arb_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] in_data4;
  logic [3:0]   in_valid4;
  logic [3:0]   in_ready4;
  logic [31:0]  out_data4;
  logic [1:0]   out_sel4;
  logic         out_valid4;
  logic         out_ready4;

  logic [23:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [7:0]   out_data3;
  logic [1:0]   out_sel3;
  logic         out_valid3;
  logic         out_ready3;

`ifdef MUXN_LOCK_EN
  logic [3:0] in_last4;
  logic       out_last4;
  logic       dbg_state4;
  logic [2:0] in_last3;
  logic       out_last3;
  logic       dbg_state3;
`endif

  muxn_arb_reg #(.WIDTH(32), .CHANNELS(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_sel   (out_sel4),
    .out_valid (out_valid4),
    .out_ready (out_ready4)
`ifdef MUXN_LOCK_EN
    ,
    .in_last   (in_last4),
    .out_last  (out_last4),
    .dbg_state (dbg_state4)
`endif
  );

  muxn_arb_reg #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
`ifdef MUXN_LOCK_EN
    ,
    .in_last   (in_last3),
    .out_last  (out_last3),
    .dbg_state (dbg_state3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    in_data4   = '0;
    in_valid4  = 4'b1111;
    out_ready4 = 1'b1;
    in_data3   = '0;
    in_valid3  = '0;
    out_ready3 = 1'b1;
`ifdef MUXN_LOCK_EN
    in_last4 = '1;
    in_last3 = '1;
`endif
    for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = 32'hA0 + 32'(i);
    for (int i = 0; i < 3; i++) in_data3[i*8 +: 8] = 8'h30 + 8'(i);

    // Reset state
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid4}, 32'd0);
    check("rst_out_data", out_data4, 32'd0);
    check("rst_out_sel", {30'd0, out_sel4}, 32'd0);
    check("rst_in_ready", {28'd0, in_ready4}, 32'd0);
`ifdef MUXN_LOCK_EN
    check("rst_out_last", {31'd0, out_last4}, 32'd0);
`endif

    // Single beat on channel 0
    rst = 1'b0;
    in_valid4 = 4'b0001;
    in_data4[31:0] = 32'hDEADBEEF;
    #1;
    check("first_in_ready", {28'd0, in_ready4}, 32'h1);
    tick();
    check("first_out_valid", {31'd0, out_valid4}, 32'd1);
    check("first_out_data", out_data4, 32'hDEADBEEF);
    check("first_out_sel", {30'd0, out_sel4}, 32'd0);

    // No request while loadable: empties, data holds
    in_valid4 = 4'b0000;
    tick();
    check("idle_out_valid", {31'd0, out_valid4}, 32'd0);
    check("idle_out_data", out_data4, 32'hDEADBEEF);

    // All valid, pointer starts at 1 after the channel-0 beat
    in_data4[31:0] = 32'hA0;
    in_valid4 = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      g = (1 + k) % 4;
      #1;
      check("rr_in_ready", {28'd0, in_ready4}, 32'(1) << g);
      tick();
      check("rr_out_valid", {31'd0, out_valid4}, 32'd1);
      check("rr_out_sel", {30'd0, out_sel4}, 32'(g));
      check("rr_out_data", out_data4, 32'hA0 + 32'(g));
    end

    // Backpressure: output full with channel 0 word
    out_ready4 = 1'b0;
    in_valid4  = 4'b0110;
    #1;
    check("bp_in_ready", {28'd0, in_ready4}, 32'd0);
    tick();
    check("bp_hold_valid", {31'd0, out_valid4}, 32'd1);
    check("bp_hold_sel", {30'd0, out_sel4}, 32'd0);
    check("bp_hold_data", out_data4, 32'hA0);
    in_valid4 = 4'b1000;
    in_data4[31:0] = 32'h11111111;
    #1;
    check("bp_in_ready2", {28'd0, in_ready4}, 32'd0);
    tick();
    check("bp_hold_data2", out_data4, 32'hA0);
    check("bp_hold_sel2", {30'd0, out_sel4}, 32'd0);

    // Drain and reload in the same cycle; pointer is 1
    out_ready4 = 1'b1;
    in_valid4  = 4'b0110;
    #1;
    check("drain_in_ready", {28'd0, in_ready4}, 32'h2);
    tick();
    check("drain_out_valid", {31'd0, out_valid4}, 32'd1);
    check("drain_out_sel", {30'd0, out_sel4}, 32'd1);
    check("drain_out_data", out_data4, 32'hA1);

    // Asynchronous reset with a full output register
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid4}, 32'd0);
    check("arst_out_data", out_data4, 32'd0);
    check("arst_out_sel", {30'd0, out_sel4}, 32'd0);
    check("arst_in_ready", {28'd0, in_ready4}, 32'd0);
    tick();
    rst = 1'b0;
    in_valid4 = 4'b1010;
    #1;
    check("post_rst_in_ready", {28'd0, in_ready4}, 32'h2);
    tick();
    check("post_rst_out_sel", {30'd0, out_sel4}, 32'd1);
    check("post_rst_out_data", out_data4, 32'hA1);
    in_valid4 = 4'b0000;

    // Three channels: pointer wraps at 2
    in_valid3 = 3'b111;
    for (int k = 0; k < 6; k++) begin
      g = k % 3;
      #1;
      check("c3_in_ready", {29'd0, in_ready3}, 32'(1) << g);
      tick();
      check("c3_out_sel", {30'd0, out_sel3}, 32'(g));
      check("c3_out_data", {24'd0, out_data3}, 32'h30 + 32'(g));
    end
    in_valid3 = 3'b000;

`ifdef MUXN_LOCK_EN
    // Channel 1 sends a 3-beat burst while channels 0 and 2 compete
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid4 = 4'b0110;
    in_last4  = 4'b0100;
    #1;
    check("lk_b1_in_ready", {28'd0, in_ready4}, 32'h2);
    tick();
    check("lk_b1_sel", {30'd0, out_sel4}, 32'd1);
    check("lk_b1_last", {31'd0, out_last4}, 32'd0);
    check("lk_b1_state", {31'd0, dbg_state4}, 32'd1);
    in_valid4 = 4'b0111;
    #1;
    check("lk_b2_in_ready", {28'd0, in_ready4}, 32'h2);
    tick();
    check("lk_b2_sel", {30'd0, out_sel4}, 32'd1);
    check("lk_b2_last", {31'd0, out_last4}, 32'd0);
    in_last4 = 4'b0110;
    tick();
    check("lk_b3_sel", {30'd0, out_sel4}, 32'd1);
    check("lk_b3_last", {31'd0, out_last4}, 32'd1);
    check("lk_b3_state", {31'd0, dbg_state4}, 32'd0);
    #1;
    check("lk_b4_in_ready", {28'd0, in_ready4}, 32'h4);
    tick();
    check("lk_b4_sel", {30'd0, out_sel4}, 32'd2);
    check("lk_b4_data", out_data4, 32'hA2);
    check("lk_b4_last", {31'd0, out_last4}, 32'd1);
    in_valid4 = 4'b0000;
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muxn_arb_reg.md
# muxn_arb_reg

Parametrised N-channel successor to the sail-core 2-to-1 word mux. It selects one of `CHANNELS` valid/ready input streams by round-robin arbitration and drives the selected word into a single-entry output register with valid/ready handshake. It sits between multiple producers, such as fetch/LSU request sources, and a single shared consumer port in the core.

## Interface
Parameters:
- `WIDTH`, 32, data width per channel (1..32).
- `CHANNELS`, 4, number of input channels (2..8; need not be a power of two).
- `SELW`, `$clog2(CHANNELS)`, width of the channel index (derived; not overridden).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  CHANNELS*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  CHANNELS  per-channel valid.
- `in_ready`  out  CHANNELS  per-channel ready; at most one bit set (one-hot or zero).
- `out_data`  out  WIDTH  registered selected word.
- `out_sel`  out  SELW  index of the channel that produced `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `in_last`  in  CHANNELS  end-of-burst marker per channel (only with `MUXN_LOCK_EN`).
- `out_last`  out  1  registered `in_last` of the selected beat (only with `MUXN_LOCK_EN`).

## Operation
- `load = !rst && (!out_valid || out_ready)`. This means the output register is empty or is being drained this cycle.
- Round-robin pointer `ptr` (SELW bits) gives the highest-priority channel. The grant goes to the first `i` with `in_valid[i]` set, scanning `ptr, ptr+1, …` modulo `CHANNELS`.
- `in_ready[g] = load` for granted channel `g`. All other `in_ready` bits are 0. `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready`, `ptr` and the lock state.
- Transfer on channel g (`in_valid[g] && in_ready[g]`):
  - `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
  - `ptr <= (g == CHANNELS-1) ? 0 : g+1`. The pointer wraps at CHANNELS-1, not at 2^SELW.
- No transfer while `load`: `out_valid <= 0`, and `out_data`/`out_sel` hold.
- `load == 0` (out_valid && !out_ready): `out_data`, `out_sel`, `out_valid` are held bit-stable.
- Simultaneous drain and new transfer: a back-to-back beat, giving sustained throughput of 1 word/cycle.
- `out_sel` never exceeds CHANNELS-1.
- Arithmetic: index comparisons and increments are unsigned SELW-bit values. No data arithmetic.

## Timing
- Reset values (asynchronous, immediate): `out_valid=0`, `out_data=0`, `out_sel=0`, `out_last=0`, `ptr=0`, lock cleared. `in_ready=0` while `rst` is high.
- Latency: an input accepted at edge n appears on `out_data` after edge n, so it is valid in cycle n+1.
- Reset mid-operation: the held output word and any lock are discarded. After release, channel 0 has top priority.
- Starvation bound: a channel holding `in_valid` is granted within CHANNELS transfers. With the lock feature, the bound is within CHANNELS bursts.

## Configuration
- `MUXN_LOCK_EN` defined:
  - Adds `in_last`/`out_last` and a two-state FSM, IDLE and LOCKED(owner).
  - In IDLE, a transfer with `in_last[g]=0` moves the FSM to LOCKED(g), and `ptr` does not advance.
  - In LOCKED, only the owner is eligible. A transfer with `in_last[owner]=1` returns the FSM to IDLE and sets `ptr = owner+1` (wrapped).
  - An owner with `in_valid` low stalls the port and no other channel is granted.
- `MUXN_LOCK_EN` undefined:
  - The ports are absent, there is no FSM, and every beat is arbitrated independently.

## Test plan
- Reset, then `in_valid=4'b0001`, `in_data[0]=32'hDEADBEEF`, `out_ready=1`: `in_ready=4'b0001`. Next cycle `out_valid=1`, `out_data=DEADBEEF`, `out_sel=0`.
- All four channels valid continuously with `out_ready=1`: `out_sel` sequence is 0,1,2,3,0,… with one beat per cycle and no gaps.
- `out_ready=0` with the output full and inputs changing: `out_data`/`out_sel` hold stable and `in_ready=0`. Raising `out_ready` gives a drain and a new load in the same cycle.
- `CHANNELS=3`, all valid: `out_sel` runs 0,1,2,0 and the pointer never reaches 3.
- Reset asserted while `out_valid=1`: `out_valid`, `out_data` and `out_sel` go to 0 without waiting for a clock edge. The first post-reset grant goes to the lowest valid index.
- With `MUXN_LOCK_EN`, channel 1 sends a 3-beat burst (`in_last` on beat 3) while channel 2 is valid: `out_sel` reads 1,1,1, then 2.
